// File: rtl/matvec8_pkg.sv
// Shared widths, word types and controller state encoding for the 8x8 matrix-vector multiplier.
package matvec8_pkg;
    localparam int N     = 8;
    localparam int IN_W  = 14;
    localparam int OUT_W = 2 * IN_W;

    typedef logic signed [IN_W-1:0]  in_t;
    typedef logic signed [OUT_W-1:0] out_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;
endpackage

// File: rtl/matvec8_mac.sv
// Single multiply-accumulate lane: full-width signed product, wrapping accumulation.
import matvec8_pkg::*;

module matvec8_mac (
    input  logic clk,
    input  logic reset,
    input  in_t  a,
    input  in_t  b,
    input  logic clear,
    input  logic en,
    output out_t acc
);
    out_t acc_reg;
    out_t prod;

    // Sign-extend before multiplying so the 28-bit product is exact.
    assign prod = out_t'(a) * out_t'(b);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= clear ? prod : acc_reg + prod;
        end
    end

    assign acc = acc_reg;
endmodule

// File: rtl/matvec8_part4.sv
// Streaming y = M*v: loads an optional row-major matrix plus a vector, then
// computes and emits one row result at a time through a single MAC lane.
import matvec8_pkg::*;

module matvec8_part4 (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic signed [IN_W-1:0]  input_data,
    input  logic                    new_matrix,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic signed [OUT_W-1:0] output_data
);
    state_t     state_reg, state_next;
    logic       ready_reg;
    logic       first_reg, mode_reg;
    logic [5:0] mat_idx_reg;
    logic [2:0] vec_idx_reg;
    logic [2:0] row_reg, col_reg;
    logic       issue_done_reg;
    logic       rd_valid_reg, rd_first_reg, rd_last_reg, mac_done_reg;
    in_t        mat_mem [N*N];
    in_t        vec_mem [N];
    in_t        a_reg, b_reg;
    out_t       acc, out_reg;

    logic in_fire, out_fire, last_vec, issue, to_matrix;

    assign in_fire   = input_valid & ready_reg;
    assign out_fire  = output_ready & (state_reg == OUTPUT);
    assign to_matrix = first_reg ? new_matrix : mode_reg;
    assign last_vec  = in_fire & ~first_reg & ~mode_reg & (vec_idx_reg == 3'd7);
    assign issue     = (state_reg == COMPUTE) & ~issue_done_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (last_vec)     state_next = COMPUTE;
            COMPUTE: if (mac_done_reg) state_next = OUTPUT;
            OUTPUT:  if (out_fire)     state_next = (row_reg == 3'd7) ? LOAD : COMPUTE;
            default:                   state_next = LOAD;
        endcase
    end

    // Storage: indices wrap back to zero at the end of each group, so the
    // first word of every group lands at address 0 without extra muxing.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (to_matrix) begin
                mat_mem[mat_idx_reg] <= input_data;
            end else begin
                vec_mem[vec_idx_reg] <= input_data;
            end
        end
        if (issue) begin
            a_reg <= mat_mem[{row_reg, col_reg}];
            b_reg <= vec_mem[col_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= LOAD;
            ready_reg      <= 1'b0;
            first_reg      <= 1'b1;
            mode_reg       <= 1'b0;
            mat_idx_reg    <= '0;
            vec_idx_reg    <= '0;
            row_reg        <= '0;
            col_reg        <= '0;
            issue_done_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_first_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            mac_done_reg   <= 1'b0;
            out_reg        <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == LOAD);
            if (in_fire) begin
                if (to_matrix) begin
                    mat_idx_reg <= mat_idx_reg + 6'd1;
                    mode_reg    <= (mat_idx_reg != 6'd63);
                end else begin
                    vec_idx_reg <= vec_idx_reg + 3'd1;
                end
                first_reg <= last_vec;
            end

            // Read issue runs one cycle ahead of the MAC; flags travel with the operands.
            rd_valid_reg <= issue;
            rd_first_reg <= issue & (col_reg == 3'd0);
            rd_last_reg  <= issue & (col_reg == 3'd7);
            if (issue) begin
                col_reg <= col_reg + 3'd1;
                if (col_reg == 3'd7) begin
                    issue_done_reg <= 1'b1;
                end
            end
            mac_done_reg <= rd_valid_reg & rd_last_reg;
            if (mac_done_reg) begin
                out_reg <= acc;
            end

            if (out_fire) begin
                row_reg        <= row_reg + 3'd1;
                col_reg        <= '0;
                issue_done_reg <= 1'b0;
            end
        end
    end

    matvec8_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .a     (a_reg),
        .b     (b_reg),
        .clear (rd_first_reg),
        .en    (rd_valid_reg),
        .acc   (acc)
    );

    assign input_ready  = ready_reg;
    assign output_valid = (state_reg == OUTPUT);
    assign output_data  = out_reg;
endmodule

// File: tb/tb_matvec8_part4.sv
// Directed plus randomized checks of matvec8_part4 against an arithmetic reference model.
module tb_matvec8_part4;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               input_valid = 1'b0;
    logic               input_ready;
    logic signed [13:0] input_data = '0;
    logic               new_matrix = 1'b0;
    logic               output_valid;
    logic               output_ready = 1'b0;
    logic signed [27:0] output_data;

    int tests = 0;
    int fails = 0;
    int stray = 0;
    bit check_stray = 0;

    always #5 clk = ~clk;

    matvec8_part4 dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    always @(negedge clk) begin
        if (check_stray && output_valid) stray++;
    end

    int m1 [64] = '{10, -20, 30, -40, 50, -60, 70, 80,
                    -90, 100, -110, 120, -130, 140, -150, 160,
                    -5, 15, -55, 42, 119, -41, 6, -2,
                    11, -11, 15, -92, 36, -44, 17, 22,
                    -84, 106, -104, 126, 115, -45, 2, -6,
                    1, 21, -49, 48, 32, -48, 13, 18,
                    17, -5, 21, -86, 111, -49, -2, -10,
                    -78, 112, -98, 132, 28, -52, 9, 14};
    int v1 [8] = '{-50, 40, 32, -16, 11, -49, 49, 111};
    int v2 [8] = '{22, -41, 42, 62, 4, -55, 7, -8};
    int y1 [8] = '{16100, 5180, 1808, 6789, 5998, 3793, 3412, 7983};
    int y2 [8] = '{3170, -13810, 2358, -1874, 247, 2794, -666, 683};

    function automatic void model(input int m [64], input int v [8], output int y [8]);
        for (int r = 0; r < 8; r++) begin
            longint s;
            logic signed [27:0] t;
            s = 0;
            for (int c = 0; c < 8; c++) s += longint'(m[r*8+c]) * longint'(v[c]);
            t = s[27:0];
            y[r] = int'(t);
        end
    endfunction

    task automatic idle_inputs();
        input_valid = 1'b0;
        input_data  = 14'($urandom);
        new_matrix  = 1'($urandom);
    endtask

    task automatic send_word(input int d, input bit nm, input bit rnd);
        int n;
        n = 0;
        while (rnd && $urandom_range(0, 2) == 0) begin
            idle_inputs();
            @(posedge clk); #1;
        end
        input_valid = 1'b1;
        input_data  = 14'(d);
        new_matrix  = nm;
        while (!input_ready && n <= 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n > 200) begin
            tests++;
            assert (n <= 200) else begin
                fails++;
                $error("FAIL input_timeout waited %0d cycles, required <= 200", n);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic send_group(input int m [64], input int v [8], input bit wm, input bit rnd);
        check_stray = 1;
        if (wm) begin
            for (int i = 0; i < 64; i++) send_word(m[i], (i == 0) ? 1'b1 : 1'($urandom), rnd);
        end
        for (int i = 0; i < 8; i++) send_word(v[i], (i == 0) ? wm : 1'($urandom), rnd);
        check_stray = 0;
    endtask

    task automatic recv_group(input int exp [8], input bit rnd, input string tag);
        for (int i = 0; i < 8; i++) begin
            int n;
            logic signed [27:0] e;
            n = 0;
            e = 28'(exp[i]);
            output_ready = rnd ? 1'($urandom) : 1'b1;
            while (!(output_valid === 1'b1 && output_ready === 1'b1) && n <= 300) begin
                @(posedge clk); #1;
                n++;
                output_ready = rnd ? 1'($urandom) : 1'b1;
            end
            tests++;
            if (rnd) begin
                assert (n <= 300) else begin
                    fails++;
                    $error("FAIL %s_timeout y[%0d] waited %0d cycles, required <= 300", tag, i, n);
                end
            end else begin
                assert (n <= 10) else begin
                    fails++;
                    $error("FAIL %s_latency y[%0d] waited %0d cycles, required <= 10", tag, i, n);
                end
            end
            tests++;
            assert (output_data === e) else begin
                fails++;
                $error("FAIL %s y[%0d] got %0d expected %0d", tag, i, output_data, e);
            end
            $display("[TB] %s y[%0d] = %0d (expected %0d)", tag, i, output_data, e);
            @(posedge clk); #1;
            output_ready = rnd ? 1'($urandom) : 1'b0;
        end
        output_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        tests++;
        assert (input_ready === 1'b0) else begin
            fails++; $error("FAIL %s_ready got %b expected 0", tag, input_ready);
        end
        tests++;
        assert (output_valid === 1'b0) else begin
            fails++; $error("FAIL %s_valid got %b expected 0", tag, output_valid);
        end
        tests++;
        assert (output_data === 28'sd0) else begin
            fails++; $error("FAIL %s_data got %0d expected 0", tag, output_data);
        end
    endtask

    initial begin
        int ma [64];
        int va [8];
        int ye [8];
        int cnt;

        // Reset, then checks of the post-reset state
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Test 1/2: directed matrix+vector, then vector only
        send_group(m1, v1, 1'b1, 1'b0);
        recv_group(y1, 1'b0, "t1");
        send_group(m1, v2, 1'b0, 1'b0);
        recv_group(y2, 1'b0, "t2");

        // Test 3: same groups with random valid/ready gaps
        send_group(m1, v1, 1'b1, 1'b1);
        recv_group(y1, 1'b1, "t3a");
        send_group(m1, v2, 1'b0, 1'b1);
        recv_group(y2, 1'b1, "t3b");

        // Test 4: idle with output_ready held high
        output_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (output_valid !== 1'b0) cnt++;
        end
        output_ready = 1'b0;
        tests++;
        assert (cnt == 0) else begin
            fails++; $error("FAIL idle_valid asserted %0d cycles, required 0", cnt);
        end

        // Test 5: extreme values
        for (int i = 0; i < 64; i++) ma[i] = -8192;
        for (int i = 0; i < 8; i++) va[i] = -8192;
        model(ma, va, ye);
        send_group(ma, va, 1'b1, 1'b0);
        recv_group(ye, 1'b0, "t5neg");
        for (int i = 0; i < 64; i++) ma[i] = 1;
        for (int i = 0; i < 8; i++) va[i] = 1;
        model(ma, va, ye);
        send_group(ma, va, 1'b1, 1'b1);
        recv_group(ye, 1'b1, "t5one");

        // Random matrices, each followed by a vector-only group reusing it
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 64; i++) ma[i] = int'($urandom_range(0, 16383)) - 8192;
            for (int i = 0; i < 8; i++) va[i] = int'($urandom_range(0, 16383)) - 8192;
            model(ma, va, ye);
            send_group(ma, va, 1'b1, 1'b1);
            recv_group(ye, 1'b1, "rnd_mat");
            for (int i = 0; i < 8; i++) va[i] = int'($urandom_range(0, 16383)) - 8192;
            model(ma, va, ye);
            send_group(ma, va, 1'b0, 1'b1);
            recv_group(ye, 1'b1, "rnd_vec");
        end

        // Test 6: reset after 30 matrix words, then full reload
        check_stray = 1;
        for (int i = 0; i < 30; i++) send_word(m1[i], (i == 0) ? 1'b1 : 1'($urandom), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("t6_reset");
        reset = 1'b0;
        send_group(m1, v1, 1'b1, 1'b0);
        tests++;
        assert (stray == 0) else begin
            fails++; $error("FAIL stray_valid seen %0d cycles, required 0", stray);
        end
        recv_group(y1, 1'b0, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
